packet_checker: RTL and testbench
=================================

Name: packet_checker

Overview:
- Receive-side checker directly downstream of the packet builder. It consumes the builder's AXI-Stream output, which has no tready, so every valid beat is accepted.
- Per frame it checks the Ethernet header against configured values, checks that the payload bytes are uniform, and checks that tkeep is legal.
- Reports per-frame length and error flags, and keeps saturating statistics counters for the traffic generator's status registers.

Parameters:
- DATA_WIDTH, 128, stream data width in bits. Must be a power of two and at least 128, so the 14-byte header plus the first filler byte (byte 14) fit in the first beat.
- N_BYTES, DATA_WIDTH/8, bytes per beat. Local, derived.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- axis_tvalid  input  1  beat valid
- axis_tlast  input  1  last beat of frame
- axis_tkeep  input  N_BYTES  byte enables
- axis_tdata  input  DATA_WIDTH  data; byte k = tdata[8k+7:8k]
- cfg_d_mac  input  48  expected destination MAC, compared against first-beat bytes 0..5 (tdata[47:0])
- cfg_s_mac  input  48  expected source MAC, compared against tdata[95:48]
- cfg_ethertype  input  16  expected ethertype, compared against tdata[111:96]
- stat_clear  input  1  zero all statistics counters
- pkt_done  output  1  one-cycle pulse per completed frame
- pkt_len  output  11  byte length of the completed frame
- pkt_err  output  5  error flags of the completed frame: {keep, payload, etype, smac, dmac}
- pkt_count  output  32  frames seen, saturating
- err_count  output  32  frames with any error flag set, saturating
- byte_total  output  48  sum of pkt_len over all frames, saturating

Behaviour:
- Reset: every output is 0; the state machine goes to IDLE; all per-frame registers are cleared. A reset asserted mid-frame discards that frame: no pkt_done is produced for it and no counter is updated. The checker resumes by treating the next valid beat as a first beat.
- State machine, two states:
  - IDLE: waiting for a first beat. A valid beat with tlast=0 moves to BODY. A valid beat with tlast=1 is a single-beat frame; the state stays IDLE.
  - BODY: inside a frame. A valid beat with tlast=1 returns to IDLE.
  - tvalid=0: no state change and no accumulation, in either state.
- First beat (valid beat while in IDLE):
  - Latch filler = byte 14.
  - Set the dmac, smac and etype flags if the corresponding fields mismatch the cfg inputs.
  - cfg inputs are sampled only on the first beat; changes mid-frame do not affect that frame.
  - The first beat's tkeep must be all ones, even if tlast=1; otherwise set the keep flag.
  - Set the payload flag if any of bytes 15..N_BYTES-1 differs from byte 14.
- Body beats:
  - Every valid byte (tkeep bit = 1) must equal the latched filler; otherwise set the payload flag.
  - Non-last beats must have tkeep all ones.
  - The last beat's tkeep must be nonzero and contiguous from bit 0 (2^k - 1 form, k >= 1). Otherwise set the keep flag.
  - Masked-off bytes are never compared.
- Length: running sum of popcount(tkeep) over the frame's beats, 11 bits wide. If the sum would exceed 2047, clamp it to 2047 and set the keep flag.
- Latency: a tlast beat sampled at cycle N produces pkt_done=1 at N+1, with pkt_len and pkt_err valid in that same cycle.
  - pkt_len and pkt_err hold their values until the next pkt_done.
  - Back-to-back frames (a new first beat at N+1) are fully supported; the accumulators restart with no bubble.
- Counters: at each pkt_done, pkt_count+1, err_count+1 if pkt_err != 0, and byte_total+pkt_len. Each saturates at its all-ones value and never wraps.
- stat_clear:
  - Zeroes the counters on the next edge. It does not affect the state machine, the in-flight frame, pkt_len or pkt_err.
  - If stat_clear and a pkt_done counter update fall on the same edge, the clear is applied first and then the completing frame is added (e.g. pkt_count = 1).
- Flag sticking: per-frame flags are sticky within a frame and cleared at the start of each new frame.

Test Plan:
- DATA_WIDTH=128, cfg matches; one beat, tkeep=FFFF, tlast=1, filler 0xA5 -> pkt_done one cycle later; pkt_len=16, pkt_err=0, pkt_count=1, byte_total=16.
- 3-beat frame of 40 bytes (last tkeep=00FF), followed back-to-back by a 1-beat frame -> two pkt_done pulses on consecutive frame ends; lengths 40 then 16; byte_total=56.
- Frame with source MAC differing in byte 7 and one body byte = 0x00 instead of filler 0x5A -> pkt_err=5'b01010, err_count=1.
- Last beat tkeep=00F0, then a separate frame with a middle beat tkeep=7FFF -> keep flag (bit 4) set for both frames; err_count=2.
- Assert rst mid-frame after 2 beats, then send a clean 1-beat frame -> no pkt_done for the aborted frame; next frame gives pkt_err=0, pkt_count=1.
- stat_clear on the same edge as a pkt_done counter update, with pkt_count=7 -> pkt_count=1 and byte_total equal to that frame's length; preload pkt_count to 0xFFFFFFFF (force) and complete a frame -> pkt_count stays 0xFFFFFFFF.

Source files
------------

// File: rtl/packet_checker.sv
// Receive-side frame checker for the packet builder stream: validates the Ethernet
// header, payload uniformity and tkeep legality, and keeps saturating statistics.
module packet_checker #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      axis_tvalid,
    input  logic                      axis_tlast,
    input  logic [DATA_WIDTH/8-1:0]   axis_tkeep,
    input  logic [DATA_WIDTH-1:0]     axis_tdata,
    input  logic [47:0]               cfg_d_mac,
    input  logic [47:0]               cfg_s_mac,
    input  logic [15:0]               cfg_ethertype,
    input  logic                      stat_clear,
    output logic                      pkt_done,
    output logic [10:0]               pkt_len,
    output logic [4:0]                pkt_err,
    output logic [31:0]               pkt_count,
    output logic [31:0]               err_count,
    output logic [47:0]               byte_total
);
    localparam int N_BYTES = DATA_WIDTH / 8;
    localparam int CW      = $clog2(N_BYTES + 1);

    typedef enum logic {IDLE, BODY} state_t;

    state_t       state;
    logic [7:0]   filler;
    logic [10:0]  len_acc;
    logic [4:0]   flags_acc;

    logic                first;
    logic                frame_end;
    logic [CW-1:0]       beat_cnt;
    logic [N_BYTES-1:0]  keep_plus;
    logic [7:0]          ref_byte;
    logic                keep_bad, payload_bad, dmac_bad, smac_bad, etype_bad, len_ovf;
    logic [11:0]         len_sum;
    logic [10:0]         len_next;
    logic [4:0]          flags_next;

    logic [31:0]  pc_base, ec_base, pc_next, ec_next;
    logic [47:0]  bt_base, bt_next;
    logic [48:0]  bt_sum;

    assign first     = (state == IDLE);
    assign frame_end = axis_tvalid && axis_tlast;

    always_comb begin
        beat_cnt = '0;
        for (int k = 0; k < N_BYTES; k++) begin
            beat_cnt = beat_cnt + CW'(axis_tkeep[k]);
        end

        // A legal last beat is 2^k-1: adding one clears every set bit.
        keep_plus = axis_tkeep + N_BYTES'(1);
        if (first || !axis_tlast) begin
            keep_bad = ~&axis_tkeep;
        end else begin
            keep_bad = (axis_tkeep == '0) || ((axis_tkeep & keep_plus) != '0);
        end

        ref_byte    = first ? axis_tdata[119:112] : filler;
        payload_bad = 1'b0;
        for (int k = 0; k < N_BYTES; k++) begin
            if (first) begin
                if (k >= 15 && axis_tdata[8*k +: 8] != ref_byte) payload_bad = 1'b1;
            end else begin
                if (axis_tkeep[k] && axis_tdata[8*k +: 8] != ref_byte) payload_bad = 1'b1;
            end
        end

        dmac_bad  = first && (axis_tdata[47:0]   != cfg_d_mac);
        smac_bad  = first && (axis_tdata[95:48]  != cfg_s_mac);
        etype_bad = first && (axis_tdata[111:96] != cfg_ethertype);

        len_sum    = (first ? 12'd0 : {1'b0, len_acc}) + 12'(beat_cnt);
        len_ovf    = (len_sum > 12'd2047);
        len_next   = len_ovf ? 11'h7FF : len_sum[10:0];
        flags_next = (first ? 5'b0 : flags_acc)
                   | {keep_bad | len_ovf, payload_bad, etype_bad, smac_bad, dmac_bad};
    end

    // Clear lands first, then the completing frame is added on the same edge.
    always_comb begin
        pc_base = stat_clear ? 32'd0 : pkt_count;
        ec_base = stat_clear ? 32'd0 : err_count;
        bt_base = stat_clear ? 48'd0 : byte_total;
        pc_next = pc_base;
        ec_next = ec_base;
        bt_next = bt_base;
        bt_sum  = {1'b0, bt_base} + 49'(len_next);
        if (frame_end) begin
            if (pc_base != '1) pc_next = pc_base + 32'd1;
            if (flags_next != '0 && ec_base != '1) ec_next = ec_base + 32'd1;
            bt_next = bt_sum[48] ? '1 : bt_sum[47:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            filler     <= '0;
            len_acc    <= '0;
            flags_acc  <= '0;
            pkt_done   <= 1'b0;
            pkt_len    <= '0;
            pkt_err    <= '0;
            pkt_count  <= '0;
            err_count  <= '0;
            byte_total <= '0;
        end else begin
            pkt_done   <= frame_end;
            pkt_count  <= pc_next;
            err_count  <= ec_next;
            byte_total <= bt_next;
            if (axis_tvalid) begin
                len_acc   <= len_next;
                flags_acc <= flags_next;
                if (first) filler <= axis_tdata[119:112];
                state <= axis_tlast ? IDLE : BODY;
                if (axis_tlast) begin
                    pkt_len <= len_next;
                    pkt_err <= flags_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_packet_checker.sv
// Self-checking bench for packet_checker: per-frame results go through an expected
// queue; statistics counters are checked inline by each scenario task.
module tb_packet_checker;
    localparam logic [47:0] D_MAC = 48'h0011_2233_4455;
    localparam logic [47:0] S_MAC = 48'h6677_8899_AABB;
    localparam logic [15:0] ETYPE = 16'h88B5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         axis_tvalid = 1'b0;
    logic         axis_tlast = 1'b0;
    logic [15:0]  axis_tkeep = '0;
    logic [127:0] axis_tdata = '0;
    logic [47:0]  cfg_d_mac = D_MAC;
    logic [47:0]  cfg_s_mac = S_MAC;
    logic [15:0]  cfg_ethertype = ETYPE;
    logic         stat_clear = 1'b0;
    logic         pkt_done;
    logic [10:0]  pkt_len;
    logic [4:0]   pkt_err;
    logic [31:0]  pkt_count, err_count;
    logic [47:0]  byte_total;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];   // {len[10:0], err[4:0]}

    packet_checker #(.DATA_WIDTH(128)) dut (
        .clk(clk), .rst(rst),
        .axis_tvalid(axis_tvalid), .axis_tlast(axis_tlast),
        .axis_tkeep(axis_tkeep), .axis_tdata(axis_tdata),
        .cfg_d_mac(cfg_d_mac), .cfg_s_mac(cfg_s_mac), .cfg_ethertype(cfg_ethertype),
        .stat_clear(stat_clear),
        .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_err(pkt_err),
        .pkt_count(pkt_count), .err_count(err_count), .byte_total(byte_total)
    );

    always #5 clk = ~clk;

    // Scoreboard: every pkt_done pops one expected frame result.
    always @(negedge clk) begin
        if (!rst && pkt_done) begin
            logic [15:0] e;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got len=%0d err=%b, required no pkt_done", pkt_len, pkt_err);
            end else begin
                e = exp_q.pop_front();
                if ({pkt_len, pkt_err} !== e) begin
                    n_err++;
                    $display("FAIL frame_result: got len=%0d err=%b, required len=%0d err=%b",
                             pkt_len, pkt_err, e[15:5], e[4:0]);
                end
            end
        end
    end

    function automatic logic [127:0] fill_beat(input logic [7:0] f);
        return {16{f}};
    endfunction

    function automatic logic [127:0] hdr_beat(input logic [7:0] f);
        logic [127:0] d;
        d = {16{f}};
        d[47:0]   = D_MAC;
        d[95:48]  = S_MAC;
        d[111:96] = ETYPE;
        return d;
    endfunction

    task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l,
                             input logic clr = 1'b0);
        @(negedge clk);
        axis_tvalid = 1'b1;
        axis_tdata  = d;
        axis_tkeep  = k;
        axis_tlast  = l;
        stat_clear  = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            axis_tvalid = 1'b0;
            axis_tlast  = 1'b0;
            axis_tkeep  = '0;
            axis_tdata  = 128'($urandom());
            stat_clear  = 1'b0;
        end
    endtask

    task automatic clear_stats();
        @(negedge clk);
        axis_tvalid = 1'b0;
        stat_clear  = 1'b1;
        @(negedge clk);
        stat_clear  = 1'b0;
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d frames outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_stats(input string name, input logic [31:0] pc, input logic [31:0] ec,
                               input logic [47:0] bt);
        n_vec++;
        if (pkt_count !== pc) begin
            n_err++;
            $display("FAIL %s_pkt_count: got %0h, required %0h", name, pkt_count, pc);
        end
        n_vec++;
        if (err_count !== ec) begin
            n_err++;
            $display("FAIL %s_err_count: got %0h, required %0h", name, err_count, ec);
        end
        n_vec++;
        if (byte_total !== bt) begin
            n_err++;
            $display("FAIL %s_byte_total: got %0h, required %0h", name, byte_total, bt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({pkt_done, pkt_len, pkt_err} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got done=%b len=%0d err=%b, required 0 0 0", pkt_done, pkt_len, pkt_err);
        end
        check_stats("reset", 32'd0, 32'd0, 48'd0);
    endtask

    task automatic test_single();
        send_beat(hdr_beat(8'hA5), 16'hFFFF, 1'b1);
        exp_q.push_back({11'd16, 5'b00000});
        idle(1);
        wait_drain();
        check_stats("single", 32'd1, 32'd0, 48'd16);
        idle(3);
        n_vec++;
        if (pkt_len !== 11'd16) begin
            n_err++;
            $display("FAIL len_hold: got %0d, required 16", pkt_len);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] d;
        clear_stats();
        d = fill_beat(8'h3C);
        d[127:64] = 64'hDEAD_BEEF_0BAD_F00D;   // masked-off bytes are never compared
        send_beat(hdr_beat(8'h3C), 16'hFFFF, 1'b0);
        send_beat(fill_beat(8'h3C), 16'hFFFF, 1'b0);
        send_beat(d, 16'h00FF, 1'b1);
        exp_q.push_back({11'd40, 5'b00000});
        send_beat(hdr_beat(8'h77), 16'hFFFF, 1'b1);
        exp_q.push_back({11'd16, 5'b00000});
        idle(1);
        wait_drain();
        check_stats("b2b", 32'd2, 32'd0, 48'd56);
    endtask

    task automatic test_header_errors();
        logic [127:0] d;
        clear_stats();
        d = hdr_beat(8'h5A);
        d[63:56] = d[63:56] ^ 8'h01;
        send_beat(d, 16'hFFFF, 1'b0);
        d = fill_beat(8'h5A);
        d[31:24] = 8'h00;
        send_beat(d, 16'hFFFF, 1'b1);
        exp_q.push_back({11'd32, 5'b01010});
        d = hdr_beat(8'h11);
        d[7:0] = d[7:0] ^ 8'h80;
        send_beat(d, 16'hFFFF, 1'b1);
        exp_q.push_back({11'd16, 5'b00001});
        d = hdr_beat(8'h22);
        d[111:104] = d[111:104] ^ 8'h10;
        send_beat(d, 16'hFFFF, 1'b1);
        exp_q.push_back({11'd16, 5'b00100});
        d = hdr_beat(8'h33);
        d[127:120] = 8'h34;
        send_beat(d, 16'hFFFF, 1'b1);
        exp_q.push_back({11'd16, 5'b01000});
        send_beat(hdr_beat(8'h44), 16'hFFFF, 1'b0);
        send_beat(fill_beat(8'h44), 16'hFFFF, 1'b1);
        cfg_s_mac = 48'h0;                       // mid-frame cfg change must be ignored
        exp_q.push_back({11'd32, 5'b00000});
        idle(1);
        cfg_s_mac = S_MAC;
        wait_drain();
        check_stats("hdr", 32'd5, 32'd4, 48'd112);
    endtask

    task automatic test_keep();
        logic [127:0] d;
        int n;
        clear_stats();
        send_beat(hdr_beat(8'hF0), 16'hFFFF, 1'b0);
        send_beat(fill_beat(8'hF0), 16'h00F0, 1'b1);
        exp_q.push_back({11'd20, 5'b10000});
        d = fill_beat(8'h0F);
        d[127:120] = 8'hEE;
        send_beat(hdr_beat(8'h0F), 16'hFFFF, 1'b0);
        send_beat(d, 16'h7FFF, 1'b0);
        idle(2);
        send_beat(fill_beat(8'h0F), 16'hFFFF, 1'b1);
        exp_q.push_back({11'd47, 5'b10000});
        d = fill_beat(8'h66);
        d[127:32] = 96'($urandom());
        d[127:120] = 8'h99;
        send_beat(hdr_beat(8'h66), 16'hFFFF, 1'b0);
        send_beat(d, 16'h000F, 1'b1);
        exp_q.push_back({11'd20, 5'b00000});
        send_beat(hdr_beat(8'h55), 16'h7FFF, 1'b1);
        exp_q.push_back({11'd15, 5'b10000});
        send_beat(hdr_beat(8'h12), 16'hFFFF, 1'b0);
        send_beat(fill_beat(8'h12), 16'h0000, 1'b1);
        exp_q.push_back({11'd16, 5'b10000});
        n = 128;
        send_beat(hdr_beat(8'hC3), 16'hFFFF, 1'b0);
        for (int i = 0; i < n; i++) send_beat(fill_beat(8'hC3), 16'hFFFF, i == n - 1);
        exp_q.push_back({11'd2047, 5'b10000});
        idle(1);
        wait_drain();
        check_stats("keep", 32'd6, 32'd5, 48'd2165);
    endtask

    task automatic test_reset_abort();
        clear_stats();
        send_beat(hdr_beat(8'h81), 16'hFFFF, 1'b0);
        send_beat(fill_beat(8'h81), 16'hFFFF, 1'b0);
        idle(1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        send_beat(hdr_beat(8'h82), 16'hFFFF, 1'b1);
        exp_q.push_back({11'd16, 5'b00000});
        idle(1);
        wait_drain();
        check_stats("abort", 32'd1, 32'd0, 48'd16);
    endtask

    task automatic test_stat_clear();
        clear_stats();
        for (int i = 0; i < 7; i++) begin
            send_beat(hdr_beat(8'($urandom_range(0, 255))), 16'hFFFF, 1'b1);
            exp_q.push_back({11'd16, 5'b00000});
        end
        idle(1);
        wait_drain();
        check_stats("pre_clear", 32'd7, 32'd0, 48'd112);
        send_beat(hdr_beat(8'h9D), 16'hFFFF, 1'b0);
        send_beat(fill_beat(8'h9D), 16'h000F, 1'b1, 1'b1);
        exp_q.push_back({11'd20, 5'b00000});
        idle(1);
        wait_drain();
        check_stats("clear_done", 32'd1, 32'd0, 48'd20);
    endtask

    task automatic test_saturate();
        @(negedge clk);
        force dut.pkt_count  = 32'hFFFF_FFFF;
        force dut.byte_total = 48'hFFFF_FFFF_FFF0;
        idle(2);
        release dut.pkt_count;
        release dut.byte_total;
        send_beat(hdr_beat(8'hB7), 16'hFFFF, 1'b1);
        exp_q.push_back({11'd16, 5'b00000});
        idle(1);
        wait_drain();
        check_stats("saturate", 32'hFFFF_FFFF, 32'd0, 48'hFFFF_FFFF_FFFF);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_header_errors();
        test_keep();
        test_reset_abort();
        test_stat_clear();
        test_saturate();
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
